// File: rtl/uart_rx_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
// Shared definitions for the UART receive controller and its FIFO:
//   ctrl_state_t     controller state encoding (OFF/SYNC/RUN/DRAIN, 2 bits)
//   FRAME_TICKS_DEF  default sample ticks per frame (11 bits x 16 ticks)
//   DATA_RX_DEF      byte presented on rd_data while the FIFO is empty/reset
// ----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_OFF   = 2'd0,
        CTRL_SYNC  = 2'd1,
        CTRL_RUN   = 2'd2,
        CTRL_DRAIN = 2'd3
    } ctrl_state_t;

    localparam int         FRAME_TICKS_DEF = 176;
    localparam logic [7:0] DATA_RX_DEF     = 8'h00;

endpackage

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous show-ahead FIFO holding received bytes for the host.
// Ports:
//   sample_clk  clock
//   rst_n       synchronous active-low reset (empties the FIFO)
//   push        write din (dropped when full unless a pop happens together)
//   pop         remove head entry (ignored when empty)
//   din         write data
//   dout        head entry, DATA_RX_DEF while empty
//   cnt         registered entry count, 0 .. 2**FIFO_AW
//   empty/full  registered flags
// ----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_AW = 3,
    parameter int WIDTH   = 8
) (
    input  logic               sample_clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic [FIFO_AW:0]   cnt,
    output logic               empty,
    output logic               full
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;
    logic [FIFO_AW:0]   cnt_nxt;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        cnt_nxt = cnt;
        case ({do_push, do_pop})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Pointers wrap naturally at 2**FIFO_AW; flags come from the next count
    // so they are registered alongside it.
    always_ff @(posedge sample_clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= cnt_nxt[FIFO_AW];
        end
    end

    always_ff @(posedge sample_clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? DATA_RX_DEF : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_rx_ctrl
// Sequences uart_rx in the sample_clk domain: enables the receiver only after
// the line has idled high, captures each completed byte into a show-ahead
// FIFO, and flags overrun (and optionally inter-byte timeout).
// Optional feature macro: RX_TIMEOUT_EN (timeout counter; else timeout = 0).
// Ports:
//   sample_clk, rst_n      16x baud clock, synchronous active-low reset
//   ctrl_en                host receiver on/off request
//   RXD                    serial line (idle sync and frame activity)
//   rx_ok, rxd_in          byte-complete level and byte from uart_rx
//   rx_en                  enable to uart_rx
//   rx_active              frame in progress
//   rd_en, rd_data         host pop and FIFO head
//   fifo_empty/full/cnt    FIFO status
//   clr_err                clears sticky overrun/timeout
//   overrun, timeout       sticky error flags
// ----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_AW       = 3,
    parameter int IDLE_SYNC     = 16,
    parameter int FRAME_TICKS   = FRAME_TICKS_DEF,
    parameter int TIMEOUT_TICKS = 704
) (
    input  logic               sample_clk,
    input  logic               rst_n,
    input  logic               ctrl_en,
    input  logic               RXD,
    input  logic               rx_ok,
    input  logic [7:0]         rxd_in,
    output logic               rx_en,
    output logic               rx_active,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               fifo_empty,
    output logic               fifo_full,
    output logic [FIFO_AW:0]   fifo_cnt,
    input  logic               clr_err,
    output logic               overrun,
    output logic               timeout
);

    localparam int SYNC_W  = $clog2(IDLE_SYNC + 1);
    localparam int FRAME_W = $clog2(FRAME_TICKS + 1);

    ctrl_state_t        state;
    ctrl_state_t        state_nxt;
    logic [SYNC_W-1:0]  sync_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               rx_ok_q;
    logic               rx_ok_rise;
    logic               capturing;
    logic               push;
    logic               overrun_set;

    assign capturing   = (state == CTRL_RUN) || (state == CTRL_DRAIN);
    assign rx_ok_rise  = rx_ok & ~rx_ok_q;
    assign push        = rx_ok_rise & capturing;
    assign rx_active   = (frame_cnt != '0);
    // Full implies non-empty, so any rd_en makes room for the push.
    assign overrun_set = push & fifo_full & ~rd_en;

    always_ff @(posedge sample_clk) begin
        if (!rst_n) state <= CTRL_OFF;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CTRL_OFF: begin
                if (ctrl_en) state_nxt = CTRL_SYNC;
            end
            CTRL_SYNC: begin
                if (!ctrl_en)
                    state_nxt = CTRL_OFF;
                else if (RXD && (sync_cnt == SYNC_W'(IDLE_SYNC - 1)))
                    state_nxt = CTRL_RUN;
            end
            CTRL_RUN: begin
                if (!ctrl_en) state_nxt = rx_active ? CTRL_DRAIN : CTRL_OFF;
            end
            CTRL_DRAIN: begin
                // Finish the in-flight byte, but never wait past its frame.
                if (rx_ok_rise || !rx_active) state_nxt = CTRL_OFF;
            end
            default: state_nxt = CTRL_OFF;
        endcase
    end

    // Idle-sync counts consecutive high ticks; any low tick restarts it.
    // The frame counter only starts in RUN but keeps running through DRAIN.
    always_ff @(posedge sample_clk) begin
        if (!rst_n) begin
            sync_cnt  <= '0;
            frame_cnt <= '0;
            rx_ok_q   <= 1'b0;
            rx_en     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == CTRL_SYNC && RXD) sync_cnt <= sync_cnt + 1'b1;
            else                           sync_cnt <= '0;

            if (capturing) begin
                if (frame_cnt != '0)
                    frame_cnt <= frame_cnt - 1'b1;
                else if (state == CTRL_RUN && !RXD)
                    frame_cnt <= FRAME_W'(FRAME_TICKS);
            end else begin
                frame_cnt <= '0;
            end

            rx_ok_q <= rx_ok;
            rx_en   <= capturing;
            overrun <= overrun_set | (overrun & ~clr_err);
        end
    end

    uart_rx_fifo #(
        .FIFO_AW (FIFO_AW),
        .WIDTH   (8)
    ) u_fifo (
        .sample_clk (sample_clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (rd_en),
        .din        (rxd_in),
        .dout       (rd_data),
        .cnt        (fifo_cnt),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_restart;
    logic            to_run;
    logic            to_hit;

    assign to_restart = push | (rd_en & ~fifo_empty);
    assign to_run     = ~fifo_empty & ~rx_active;
    assign to_hit     = ~to_restart & to_run & (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    // Counter saturates at TIMEOUT_TICKS so the flag fires once per idle gap.
    always_ff @(posedge sample_clk) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (to_restart)
                to_cnt <= '0;
            else if (to_run && (to_cnt != TO_W'(TIMEOUT_TICKS)))
                to_cnt <= to_cnt + 1'b1;
            timeout <= to_hit | (timeout & ~clr_err);
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl. A queue-based model tracks the FIFO
// contents and the sticky overrun flag; timing expectations (idle sync,
// frame length, timeout) are derived from the tick counts of the protocol.
// ----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int DEPTH       = 8;
    localparam int IDLE_TICKS  = 16;
    localparam int FRAME_LEN   = 176;
    localparam int TIMEOUT_LEN = 704;

    logic       sample_clk = 1'b0;
    logic       rst_n      = 1'b0;
    logic       ctrl_en    = 1'b0;
    logic       RXD        = 1'b1;
    logic       rx_ok      = 1'b0;
    logic [7:0] rxd_in     = 8'h00;
    logic       rd_en      = 1'b0;
    logic       clr_err    = 1'b0;
    logic       rx_en;
    logic       rx_active;
    logic [7:0] rd_data;
    logic       fifo_empty;
    logic       fifo_full;
    logic [3:0] fifo_cnt;
    logic       overrun;
    logic       timeout;

    int pass_count  = 0;
    int check_count = 0;

    logic [7:0] model_q [$];
    logic       model_ovr     = 1'b0;
    logic       model_prev_ok = 1'b0;
    logic       cap_on        = 1'b0;

    always #5 sample_clk = ~sample_clk;

    uart_rx_ctrl dut (
        .sample_clk (sample_clk),
        .rst_n      (rst_n),
        .ctrl_en    (ctrl_en),
        .RXD        (RXD),
        .rx_ok      (rx_ok),
        .rxd_in     (rxd_in),
        .rx_en      (rx_en),
        .rx_active  (rx_active),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_cnt   (fifo_cnt),
        .clr_err    (clr_err),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_cnt"}, fifo_cnt, model_q.size());
        checkOutput({tag, "_empty"}, fifo_empty, model_q.size() == 0);
        checkOutput({tag, "_full"}, fifo_full, model_q.size() == DEPTH);
        checkOutput({tag, "_ovr"}, overrun, model_ovr);
        if (model_q.size() > 0) checkOutput({tag, "_head"}, rd_data, model_q[0]);
    endtask

    // One clock of host/receiver activity followed by a model update and check.
    task automatic applyStimulus(input logic ok_v, input logic [7:0] byte_v,
                                 input logic rd_v, input logic clr_v);
        int   sz;
        logic pop_ok;
        logic ovr_set;
        rx_ok   = ok_v;
        rxd_in  = byte_v;
        rd_en   = rd_v;
        clr_err = clr_v;
        tick();
        sz      = model_q.size();
        pop_ok  = rd_v && (sz > 0);
        ovr_set = 1'b0;
        if (pop_ok) void'(model_q.pop_front());
        if (cap_on && ok_v && !model_prev_ok) begin
            if (sz == DEPTH && !pop_ok) ovr_set = 1'b1;
            else model_q.push_back(byte_v);
        end
        model_ovr     = ovr_set | (model_ovr & ~clr_v);
        model_prev_ok = ok_v;
        checkModel("fifo");
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
        applyStimulus(1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic drainFifo();
        for (int i = 0; i < DEPTH + 2 && model_q.size() > 0; i++)
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    // Ticks from the edge that samples ctrl_en=1 until rx_en is seen high.
    task automatic measureSync(input int glitch, output int n);
        ctrl_en = 1'b1;
        RXD     = 1'b1;
        tick();
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            RXD = (i == glitch) ? 1'b0 : 1'b1;
            tick();
            n = i;
            if (rx_en) break;
        end
        RXD = 1'b1;
    endtask

    initial begin
        int n;
        int g;
        int hold;
        logic ok_v;
        logic [7:0] cur_byte;

        // Reset state
        tick();
        tick();
        checkOutput("rst_rx_en", rx_en, 0);
        checkOutput("rst_empty", fifo_empty, 1);
        checkOutput("rst_full", fifo_full, 0);
        checkOutput("rst_cnt", fifo_cnt, 0);
        checkOutput("rst_ovr", overrun, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_active", rx_active, 0);
        checkOutput("rst_rd_data", rd_data, 8'h00);
        rst_n = 1'b1;
        tick();

        // Idle sync with clean line, then switch off on idle line
        measureSync(0, n);
        checkOutput("sync_clean", n, IDLE_TICKS + 1);
        ctrl_en = 1'b0;
        tick();
        checkOutput("off_rx_en_hold", rx_en, 1);
        tick();
        checkOutput("off_rx_en_low", rx_en, 0);

        // Glitch at tick 10 and at a random tick restarts the idle count
        measureSync(10, n);
        checkOutput("sync_glitch10", n, 10 + IDLE_TICKS + 1);
        ctrl_en = 1'b0;
        tick();
        tick();
        g = $urandom_range(1, IDLE_TICKS);
        measureSync(g, n);
        checkOutput("sync_glitch_rand", n, g + IDLE_TICKS + 1);
        cap_on = 1'b1;

        // Single byte, rx_ok held for several cycles gives exactly one entry
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hA5, 1'b0, 1'b0);
        checkOutput("a5_cnt", fifo_cnt, 1);
        checkOutput("a5_data", rd_data, 8'hA5);
        drainFifo();

        // Nine bytes into an 8-deep FIFO, then push+pop while full
        for (int i = 0; i < 9; i++) pushByte(8'h30 + 8'(i));
        checkOutput("full_flag", fifo_full, 1);
        checkOutput("full_ovr", overrun, 1);
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("full_pushpop_cnt", fifo_cnt, DEPTH);
        applyStimulus(1'b0, 8'hEE, 1'b0, 1'b1);
        drainFifo();

        // Randomized pushes, pops and error clears against the queue model
        hold = 0;
        cur_byte = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (model_prev_ok) begin
                ok_v = (hold < 3) && ($urandom_range(0, 1) == 1);
            end else begin
                ok_v = ($urandom_range(0, 2) == 0);
                if (ok_v) cur_byte = 8'($urandom);
            end
            hold = ok_v ? hold + 1 : 0;
            applyStimulus(ok_v, cur_byte, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 15) == 0);
        end
        applyStimulus(1'b0, cur_byte, 1'b0, 1'b1);
        drainFifo();

        // Switch off mid-frame: drain until the byte arrives
        RXD = 1'b0;
        tick();
        RXD = 1'b1;
        checkOutput("drain_active", rx_active, 1);
        ctrl_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checkOutput("drain_rx_en", rx_en, 1);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        cap_on = 1'b0;
        checkOutput("drain_push_rx_en", rx_en, 1);
        applyStimulus(1'b0, 8'h5A, 1'b0, 1'b0);
        checkOutput("drain_done_rx_en", rx_en, 0);
        checkOutput("drain_byte", rd_data, 8'h5A);

        // Switch off mid-frame with no byte: drain ends when the frame expires
        measureSync(0, n);
        checkOutput("resync", n, IDLE_TICKS + 1);
        cap_on = 1'b1;
        RXD = 1'b0;
        tick();
        RXD = 1'b1;
        ctrl_en = 1'b0;
        n = 0;
        while (rx_active && n < 400) begin
            tick();
            n++;
        end
        checkOutput("frame_len", n, FRAME_LEN);
        checkOutput("expire_rx_en_hold", rx_en, 1);
        tick();
        tick();
        checkOutput("expire_rx_en_low", rx_en, 0);
        cap_on = 1'b0;

        // Reset mid-frame with three entries
        measureSync(0, n);
        cap_on = 1'b1;
        drainFifo();
        pushByte(8'h11);
        pushByte(8'h22);
        pushByte(8'h33);
        RXD = 1'b0;
        tick();
        RXD = 1'b1;
        ctrl_en = 1'b0;
        rst_n = 1'b0;
        tick();
        model_q.delete();
        model_ovr = 1'b0;
        cap_on = 1'b0;
        checkOutput("midrst_rx_en", rx_en, 0);
        checkOutput("midrst_cnt", fifo_cnt, 0);
        checkOutput("midrst_empty", fifo_empty, 1);
        checkOutput("midrst_ovr", overrun, 0);
        checkOutput("midrst_active", rx_active, 0);
        checkOutput("midrst_rd_data", rd_data, 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Inter-byte timeout
        measureSync(0, n);
        cap_on = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
`ifdef RX_TIMEOUT_EN
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            applyStimulus(1'b0, 8'h77, 1'b0, 1'b0);
            n = i;
            if (timeout) break;
        end
        checkOutput("timeout_ticks", n, TIMEOUT_LEN);
        applyStimulus(1'b0, 8'h77, 1'b0, 1'b1);
        checkOutput("timeout_clr", timeout, 0);
`else
        for (int i = 0; i < TIMEOUT_LEN + 100; i++)
            applyStimulus(1'b0, 8'h77, 1'b0, 1'b0);
        checkOutput("timeout_off", timeout, 0);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
